cla_chain_adder: RTL and testbench
==================================

# cla_chain_adder

Multi-cycle wide adder built around the team's `cla_8bit` carry-lookahead adder. It accepts two `NBYTES`-byte operands over a valid/ready handshake and adds them one byte per clock, least-significant byte first. Each byte is fed through `cla_8bit` instances, and the carry between bytes is held in a register. The full-width sum with carry-out is presented on a valid/ready output. The block sits directly around the 8-bit CLA stage: it feeds that stage its operands and consumes the 9-bit sum it produces.

## Interface
- `NBYTES`, default 4: number of 8-bit limbs per operand; legal range 1–16.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous reset, active-low. Assertion is asynchronous; release is synchronous to `clk` at the system level.
- `in_valid` input, 1 bit: operand pair on `a`/`b` is valid.
- `in_ready` output, 1 bit: block can accept an operand pair.
- `a` input, 8*NBYTES bits: operand A, unsigned.
- `b` input, 8*NBYTES bits: operand B, unsigned.
- `out_valid` output, 1 bit: `sum` holds a completed result.
- `out_ready` input, 1 bit: downstream consumes the result.
- `sum` output, 8*NBYTES+1 bits: A+B, unsigned. MSB is the final carry-out.

## Operation
- **FSM states:**
  - `IDLE`: `in_ready`=1, `out_valid`=0.
  - `ADD`: `in_ready`=0, `out_valid`=0.
  - `DONE`: `in_ready`=0, `out_valid`=1.
- **IDLE → ADD:** on a clock edge with `in_valid`=1 (`in_ready` is 1 in `IDLE`).
  - Capture `a` and `b` into operand registers.
  - Clear the carry register, the byte index and the `sum` register to 0.
- **ADD, byte index i (0..NBYTES-1), one byte per cycle:**
  - Stage 1: `cla_8bit` adds `a[8i+7:8i]` + `b[8i+7:8i]`, giving 9-bit s1.
  - Stage 2: `cla_8bit` adds s1[7:0] + {7'b0, carry}, giving 9-bit s2.
  - Write s2[7:0] into `sum[8i+7:8i]`.
  - New carry = s1[8] | s2[8]. Both bits are never 1 at the same time.
  - Increment i.
- **ADD → DONE:** on the edge that processes byte NBYTES-1. That edge also writes the final carry into `sum[8*NBYTES]`.
- **DONE → IDLE:** on an edge with `out_ready`=1. `sum` keeps its value until the next accept.
- **Arithmetic:** purely unsigned. The 8*NBYTES+1-bit result never overflows.
- **Input stability:** `a` and `b` are sampled only at the accept edge. Changes to them during `ADD` or `DONE` have no effect.
- **Simultaneous events:**
  - `in_valid` is ignored outside `IDLE`.
  - `out_ready` is ignored outside `DONE`.
  - There is no accept in the same cycle as a result is consumed, so `in_ready` is 0 throughout `DONE`.
- **NBYTES=1:** `ADD` lasts one cycle. The result equals the `cla_8bit` sum with carry-in 0.

## Timing
- **Reset values:**
  - State `IDLE`: `in_ready`=1, `out_valid`=0.
  - `sum`=0; carry, index and operand registers = 0.
- **Reset mid-operation:** asserting `rst_n`=0 in `ADD` or `DONE` immediately abandons the operation.
  - Outputs take their reset values asynchronously.
  - No result is delivered for the abandoned operation.
- **Latency:** with the accept at edge E0, `out_valid` rises after edge E_NBYTES, i.e. NBYTES cycles after the accept.
- **Throughput:** one result per NBYTES+2 cycles at best. That is NBYTES `ADD` cycles, at least one `DONE` cycle, and one `IDLE` cycle.
- **Output hold:** `out_valid` and `sum` stay stable while `out_ready`=0, for any number of cycles.
- **Register boundaries:**
  - All outputs are registered or decoded directly from the state register.
  - The only combinational path inside a cycle is the two chained `cla_8bit` instances.

## Test plan
All scenarios use NBYTES=4 unless stated otherwise.
- **Reset:** hold `rst_n`=0 for 3 cycles, then release → `in_ready`=1, `out_valid`=0, `sum`=0.
- **Carry ripple:** a=32'hFFFF_FFFF, b=32'h0000_0001, `out_ready`=1 → `out_valid` rises exactly 4 cycles after the accept; `sum`=33'h1_0000_0000.
- **Mixed values:** a=32'h1234_5678, b=32'h8765_4321 → `sum`=33'h0_9999_9999. Next, a=b=32'hFFFF_FFFF → `sum`=33'h1_FFFF_FFFE.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid` → `sum` stable and `in_ready`=0 throughout; toggle `a`/`b` and `in_valid` during the wait → result unchanged. Raise `out_ready` → `IDLE` on the next edge.
- **Reset mid-operation:** pulse `rst_n`=0 during the second `ADD` cycle → outputs go to reset values immediately. A subsequent transaction 8'hFF+8'h01 per byte (a=32'hFFFF_FFFF, b=32'h0101_0101) → `sum`=33'h1_0101_0100.
- **Exhaustive single byte:** set NBYTES=1 and sweep all a,b in 0..255 → `sum` = a+b in every case, checked against a reference model.

Source files
------------

// File: rtl/cla_chain_adder.sv
// rtl/cla_chain_adder.sv - multi-cycle wide adder, one byte per clock through chained 8-bit CLAs
//
// cla_8bit        : combinational 8-bit carry-lookahead adder.
//   a_i, b_i      : 8-bit unsigned operands
//   s_o           : 9-bit sum, s_o[8] is the carry-out
//
// cla_chain_adder : NBYTES-byte adder, LSB byte first, valid/ready on both sides.
//   clk, rst_n    : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake, a/b sampled only on the accept edge
//   a, b          : 8*NBYTES-bit unsigned operands
//   out_valid/out_ready : result handshake
//   sum           : 8*NBYTES+1-bit result, MSB is the final carry-out

module cla_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [8:0] s_o
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       term;

  // Every carry is a flat sum-of-products of generate/propagate terms,
  // so no carry depends on another carry.
  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c    = '0;
    term = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i];
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        c[i+1] = c[i+1] | term;
      end
    end
    s_o = {c[8], p ^ c[7:0]};
  end

endmodule

module cla_chain_adder #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES:0]   sum
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W:0]      sum_q, sum_d;

  logic [7:0] a_byte;
  logic [7:0] b_byte;
  logic [8:0] s1;
  logic [8:0] s2;

  // Select the current limb with a shift so the index stays a plain register.
  assign a_byte = 8'(a_q >> {idx_q, 3'b000});
  assign b_byte = 8'(b_q >> {idx_q, 3'b000});

  cla_8bit u_stage1 (
    .a_i (a_byte),
    .b_i (b_byte),
    .s_o (s1)
  );

  // Second stage folds in the inter-byte carry; s1[8] and s2[8] are mutually
  // exclusive because s1[7:0] + 1 can only overflow when s1[7:0] is 8'hFF.
  cla_8bit u_stage2 (
    .a_i (s1[7:0]),
    .b_i ({7'b0, carry_q}),
    .s_o (s2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ADD;
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      ADD: begin
        for (int k = 0; k < NBYTES; k++) begin
          if (idx_q == IDXW'(k)) begin
            sum_d[8*k +: 8] = s2[7:0];
          end
        end
        carry_d = s1[8] | s2[8];
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NBYTES - 1)) begin
          sum_d[W] = s1[8] | s2[8];
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;

endmodule

// File: tb/tb_cla_chain_adder.sv
// tb/tb_cla_chain_adder.sv - self-checking bench for cla_chain_adder (NBYTES=4 and NBYTES=1)

module tb_cla_chain_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] sum;

  int n_vec = 0;
  int n_err = 0;

  // Four NBYTES=1 lanes share the exhaustive sweep so it fits the cycle budget.
  logic       e_in_valid;
  logic       e_out_ready;
  logic [7:0] e_a [4];
  logic [7:0] e_b [4];
  logic [8:0] e_sum [4];
  logic       e_in_ready [4];
  logic       e_out_valid [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cla_chain_adder #(.NBYTES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
  );

  for (genvar gl = 0; gl < 4; gl++) begin : g_lane
    cla_chain_adder #(.NBYTES(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (e_in_valid),
      .in_ready  (e_in_ready[gl]),
      .a         (e_a[gl]),
      .b         (e_b[gl]),
      .out_valid (e_out_valid[gl]),
      .out_ready (e_out_ready),
      .sum       (e_sum[gl])
    );
  end

  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    return 33'(x) + 33'(y);
  endfunction

  // Drives one transaction, holds out_ready low for 'hold' cycles after the
  // result appears, then consumes it. lat counts edges from accept to out_valid.
  task automatic run_txn(input logic [31:0] ta, input logic [31:0] tbv, input int hold,
                         output logic [32:0] got, output int lat);
    @(negedge clk);
    a = ta; b = tbv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    repeat (hold) @(negedge clk);
    got = sum;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_vec++;
    if (sum !== 33'd0) begin n_err++; $display("FAIL reset_sum got=%h exp=0", sum); end
    for (int l = 0; l < 4; l++) begin
      n_vec++;
      if (e_in_ready[l] !== 1'b1 || e_out_valid[l] !== 1'b0 || e_sum[l] !== 9'd0) begin
        n_err++;
        $display("FAIL reset_lane%0d in_ready=%b out_valid=%b sum=%h exp 1/0/0",
                 l, e_in_ready[l], e_out_valid[l], e_sum[l]);
      end
    end
  endtask

  task automatic test_carry_ripple;
    logic [32:0] got;
    int lat;
    run_txn(32'hFFFF_FFFF, 32'h0000_0001, 0, got, lat);
    n_vec++;
    if (lat !== 4) begin n_err++; $display("FAIL ripple_latency got=%0d exp=4", lat); end
    n_vec++;
    if (got !== 33'h1_0000_0000) begin n_err++; $display("FAIL ripple_sum got=%h exp=100000000", got); end
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL ripple_return_idle in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_mixed;
    logic [32:0] got;
    int lat;
    run_txn(32'h1234_5678, 32'h8765_4321, 0, got, lat);
    n_vec++;
    if (got !== 33'h0_9999_9999) begin n_err++; $display("FAIL mixed_sum got=%h exp=099999999", got); end
    run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, got, lat);
    n_vec++;
    if (got !== 33'h1_FFFF_FFFE) begin n_err++; $display("FAIL all_ones_sum got=%h exp=1fffffffe", got); end
  endtask

  task automatic test_backpressure;
    logic [32:0] exp_sum;
    int lat;
    exp_sum = ref_add(32'hDEAD_BEEF, 32'h3456_789A);
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h3456_789A; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_vec++;
    if (lat !== 4) begin n_err++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    for (int c = 0; c < 10; c++) begin
      a = $urandom; b = $urandom; in_valid = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== exp_sum) begin
        n_err++;
        $display("FAIL bp_hold cyc=%0d out_valid=%b in_ready=%b sum=%h exp 1/0/%h",
                 c, out_valid, in_ready, sum, exp_sum);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== exp_sum) begin
      n_err++;
      $display("FAIL bp_release in_ready=%b out_valid=%b sum=%h exp 1/0/%h", in_ready, out_valid, sum, exp_sum);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [32:0] got;
    int lat;
    int seen;
    @(negedge clk);
    a = 32'h0000_0077; b = 32'h0000_0011; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 33'd0) begin
      n_err++;
      $display("FAIL midreset_async in_ready=%b out_valid=%b sum=%h exp 1/0/0", in_ready, out_valid, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    out_ready = 1'b0;
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL midreset_no_result got=%0d exp=0", seen); end
    run_txn(32'hFFFF_FFFF, 32'h0101_0101, 0, got, lat);
    n_vec++;
    if (got !== 33'h1_0101_0100) begin n_err++; $display("FAIL midreset_next_sum got=%h exp=101010100", got); end
  endtask

  task automatic test_random;
    logic [31:0] ra, rb;
    logic [32:0] got;
    int lat;
    for (int t = 0; t < 30; t++) begin
      ra = $urandom; rb = $urandom;
      if (t % 5 == 0) ra = 32'hFFFF_FFFF - rb;
      run_txn(ra, rb, $urandom_range(0, 3), got, lat);
      n_vec++;
      if (got !== ref_add(ra, rb) || lat !== 4) begin
        n_err++;
        $display("FAIL random_txn%0d a=%h b=%h sum=%h lat=%0d exp sum=%h lat=4",
                 t, ra, rb, got, lat, ref_add(ra, rb));
      end
    end
  endtask

  task automatic test_exhaustive_byte;
    e_in_valid = 1'b0;
    e_out_ready = 1'b0;
    for (int ai = 0; ai < 64; ai++) begin
      for (int bi = 0; bi < 256; bi++) begin
        @(negedge clk);
        for (int l = 0; l < 4; l++) begin
          e_a[l] = 8'(l * 64 + ai);
          e_b[l] = 8'(bi);
        end
        e_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        e_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 4; l++) begin
          n_vec++;
          if (e_out_valid[l] !== 1'b1 || e_sum[l] !== 9'(l * 64 + ai + bi)) begin
            n_err++;
            $display("FAIL byte_sweep lane%0d a=%0d b=%0d out_valid=%b sum=%0d exp 1/%0d",
                     l, l * 64 + ai, bi, e_out_valid[l], e_sum[l], l * 64 + ai + bi);
          end
        end
        e_out_ready = 1'b1;
        @(posedge clk);
        #1;
        e_out_ready = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    e_in_valid = 1'b0;
    e_out_ready = 1'b0;
    for (int l = 0; l < 4; l++) begin
      e_a[l] = '0;
      e_b[l] = '0;
    end
    test_reset();
    test_carry_ripple();
    test_mixed();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    test_exhaustive_byte();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
